// File: rtl/iq_pkg.sv
// Shared types and constants for the issue queue.
package iq_pkg;

    localparam int unsigned AL_SIZE = 32;

    localparam int unsigned NUM_CHECKPOINTS = 4;

    localparam int unsigned PHYS_REGS    = 64;
    localparam int unsigned TAG_W        = $clog2(PHYS_REGS);
    localparam int unsigned AL_W         = $clog2(AL_SIZE);
    localparam int unsigned CP_W         = $clog2(NUM_CHECKPOINTS);
    localparam int unsigned IQ_PAYLOAD_W = 96;

    typedef logic [TAG_W-1:0] phys_tag_t;
    typedef logic [AL_W-1:0]  al_idx_t;
    typedef logic [CP_W-1:0]  cp_id_t;

    typedef struct packed {
        logic                    valid;
        logic                    rdy1;
        logic                    rdy2;
        logic                    uses_rs1;
        logic                    uses_rs2;
        logic                    uses_rd;
        phys_tag_t               rs1;
        phys_tag_t               rs2;
        phys_tag_t               rd;
        al_idx_t                 al_idx;
        cp_id_t                  cp;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

    // Operand readiness at enqueue. Tag 0 is hardwired ready; an intra-bundle
    // producer overrides both the busy snapshot and any same-cycle wakeup.
    function automatic logic op_ready(input logic                 uses,
                                      input phys_tag_t            tag,
                                      input logic                 dep,
                                      input logic [PHYS_REGS-1:0] busy,
                                      input logic [PHYS_REGS-1:0] wake);
        if (!uses || tag == '0) return 1'b1;
        if (dep) return 1'b0;
        return !busy[tag] || wake[tag];
    endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix: age_q[i][j] = 1 means entry i is older than entry j.
// Picks the single requesting entry that no older requesting entry blocks.
module iq_age_matrix
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DEPTH-1:0] alloc0_oh,
    input  logic [DEPTH-1:0] alloc1_oh,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] oldest_oh
);

    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    // New entries are younger than everything currently valid; slot 0 beats slot 1.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc0_oh[i] || alloc1_oh[i]) age_d[i] = '0;
        end
        for (int j = 0; j < DEPTH; j++) begin
            if (alloc0_oh[j] || alloc1_oh[j]) begin
                for (int i = 0; i < DEPTH; i++) age_d[i][j] = valid[i];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (alloc0_oh[i] && alloc1_oh[j]) age_d[i][j] = 1'b1;
            end
        end
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
        end
    end

    // Matrix state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // Oldest request: no other requester has its age bit set against it.
    always_comb begin
        oldest_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (req[j] && age_q[j][i]) blocked = 1'b1;
            end
            oldest_oh[i] = req[i] && !blocked;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Two-wide enqueue, single-issue out-of-order issue queue with wakeup,
// checkpoint squash and full flush.
module issue_queue
    import iq_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned NUM_WB    = 2,
    parameter int unsigned NUM_CP    = NUM_CHECKPOINTS,
    parameter int unsigned PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid     [2],
    input  logic                      in_uses_rs1  [2],
    input  logic                      in_uses_rs2  [2],
    input  logic                      in_uses_rd   [2],
    input  phys_tag_t                 in_rs1       [2],
    input  phys_tag_t                 in_rs2       [2],
    input  phys_tag_t                 in_rd        [2],
    input  al_idx_t                   in_al_idx    [2],
    input  logic [$clog2(NUM_CP)-1:0] in_cp        [2],
    input  logic [PAYLOAD_W-1:0]      in_payload   [2],
    input  logic [PHYS_REGS-1:0]      bbt,
    input  logic                      wb_valid     [NUM_WB],
    input  phys_tag_t                 wb_tag       [NUM_WB],
    input  logic                      squash_valid,
    input  logic [NUM_CP-1:0]         squash_mask,
    output logic                      o_stall,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output phys_tag_t                 iss_rs1,
    output phys_tag_t                 iss_rs2,
    output phys_tag_t                 iss_rd,
    output logic                      iss_uses_rs1,
    output logic                      iss_uses_rs2,
    output logic                      iss_uses_rd,
    output al_idx_t                   iss_al_idx,
    output logic [$clog2(NUM_CP)-1:0] iss_cp,
    output logic [PAYLOAD_W-1:0]      iss_payload
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    iq_entry_t              ent_q [DEPTH];
    iq_entry_t              ent_d [DEPTH];
    iq_entry_t              new_ent [2];
    iq_entry_t              sel;
    logic                   stall_q, stall_d;
    logic [PHYS_REGS-1:0]   wake_vec;
    logic [1:0]             enq;
    logic [DEPTH-1:0]       alloc_oh [2];
    logic [DEPTH-1:0]       valid_vec, req_vec, squash_hit, oldest_oh;
    logic                   free0_found, free1_found;
    logic [IDX_W-1:0]       free0_idx, free1_idx;
    logic                   iss_fire;

    // Decode all writeback ports into one wakeup vector (duplicate tags just OR).
    always_comb begin
        wake_vec = '0;
        for (int w = 0; w < NUM_WB; w++) begin
            if (wb_valid[w]) wake_vec[wb_tag[w]] = 1'b1;
        end
    end

    // Build the incoming entries and decide which slots are actually accepted.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            logic dep1, dep2;
            dep1 = (s == 1) && in_valid[0] && in_uses_rd[0] && in_rd[0] == in_rs1[s];
            dep2 = (s == 1) && in_valid[0] && in_uses_rd[0] && in_rd[0] == in_rs2[s];
            new_ent[s]          = '0;
            new_ent[s].valid    = 1'b1;
            new_ent[s].rdy1     = op_ready(in_uses_rs1[s], in_rs1[s], dep1, bbt, wake_vec);
            new_ent[s].rdy2     = op_ready(in_uses_rs2[s], in_rs2[s], dep2, bbt, wake_vec);
            new_ent[s].uses_rs1 = in_uses_rs1[s];
            new_ent[s].uses_rs2 = in_uses_rs2[s];
            new_ent[s].uses_rd  = in_uses_rd[s];
            new_ent[s].rs1      = in_rs1[s];
            new_ent[s].rs2      = in_rs2[s];
            new_ent[s].rd       = in_rd[s];
            new_ent[s].al_idx   = in_al_idx[s];
            new_ent[s].cp       = in_cp[s];
            new_ent[s].payload  = in_payload[s];
            enq[s] = in_valid[s] && !stall_q && !flush
                     && !(squash_valid && squash_mask[in_cp[s]]);
        end
    end

    // Lowest and second-lowest free indices; stall_q guarantees two exist.
    always_comb begin
        free0_found = 1'b0;
        free1_found = 1'b0;
        free0_idx   = '0;
        free1_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_q[i].valid) begin
                if (!free0_found) begin
                    free0_found = 1'b1;
                    free0_idx   = IDX_W'(i);
                end else if (!free1_found) begin
                    free1_found = 1'b1;
                    free1_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Slot 1 takes the lowest free index when slot 0 is not enqueuing.
    always_comb begin
        alloc_oh[0] = '0;
        alloc_oh[1] = '0;
        if (enq[0] && free0_found) alloc_oh[0][free0_idx] = 1'b1;
        if (enq[1]) begin
            if (enq[0]) begin
                if (free1_found) alloc_oh[1][free1_idx] = 1'b1;
            end else if (free0_found) begin
                alloc_oh[1][free0_idx] = 1'b1;
            end
        end
    end

    // Issue candidates: ready, not being squashed, and no flush this cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i]  = ent_q[i].valid;
            squash_hit[i] = ent_q[i].valid && squash_valid && squash_mask[ent_q[i].cp];
            req_vec[i]    = ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2
                            && !squash_hit[i] && !flush;
        end
    end

    iq_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .alloc0_oh (alloc_oh[0]),
        .alloc1_oh (alloc_oh[1]),
        .valid     (valid_vec),
        .req       (req_vec),
        .oldest_oh (oldest_oh)
    );

    // One-hot mux of the selected entry; all-zero when nothing is ready.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (oldest_oh[i]) sel = iq_entry_t'(sel | ent_q[i]);
        end
    end

    assign iss_valid    = |req_vec;
    assign iss_fire     = iss_valid && iss_ready;
    assign iss_rs1      = sel.rs1;
    assign iss_rs2      = sel.rs2;
    assign iss_rd       = sel.rd;
    assign iss_uses_rs1 = sel.uses_rs1;
    assign iss_uses_rs2 = sel.uses_rs2;
    assign iss_uses_rd  = sel.uses_rd;
    assign iss_al_idx   = sel.al_idx;
    assign iss_cp       = sel.cp;
    assign iss_payload  = PAYLOAD_W'(sel.payload);
    assign o_stall      = stall_q;

    // Entry next state: wakeup, then issue/squash removal, then enqueue; flush wins.
    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid) begin
                if (wake_vec[ent_q[i].rs1]) ent_d[i].rdy1 = 1'b1;
                if (wake_vec[ent_q[i].rs2]) ent_d[i].rdy2 = 1'b1;
            end
            if (iss_fire && oldest_oh[i]) ent_d[i].valid = 1'b0;
            if (squash_hit[i]) ent_d[i].valid = 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (alloc_oh[s][i]) ent_d[i] = new_ent[s];
            end
            if (flush) ent_d[i] = '0;
        end
    end

    // Stall whenever fewer than two entries will be free after this edge.
    always_comb begin
        int unsigned free_cnt;
        free_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_d[i].valid) free_cnt = free_cnt + 1;
        end
        stall_d = free_cnt < 2;
    end

    // Entry array and stall register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            stall_q <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against an age-ordered model.
module tb_issue_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        in_valid[2], in_uses_rs1[2], in_uses_rs2[2], in_uses_rd[2];
    logic [5:0]  in_rs1[2], in_rs2[2], in_rd[2];
    logic [4:0]  in_al_idx[2];
    logic [1:0]  in_cp[2];
    logic [95:0] in_payload[2];
    logic [63:0] bbt;
    logic        wb_valid[2];
    logic [5:0]  wb_tag[2];
    logic        squash_valid;
    logic [3:0]  squash_mask;
    logic        o_stall, iss_valid, iss_ready;
    logic [5:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_uses_rs1, iss_uses_rs2, iss_uses_rd;
    logic [4:0]  iss_al_idx;
    logic [1:0]  iss_cp;
    logic [95:0] iss_payload;

    int n_vec = 0;
    int n_bad = 0;
    bit live  = 0;

    issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
        .in_uses_rd(in_uses_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_al_idx(in_al_idx), .in_cp(in_cp), .in_payload(in_payload), .bbt(bbt),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .squash_valid(squash_valid),
        .squash_mask(squash_mask), .o_stall(o_stall), .iss_valid(iss_valid),
        .iss_ready(iss_ready), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_uses_rs1(iss_uses_rs1), .iss_uses_rs2(iss_uses_rs2),
        .iss_uses_rd(iss_uses_rd), .iss_al_idx(iss_al_idx), .iss_cp(iss_cp),
        .iss_payload(iss_payload)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: list of instructions, oldest first
    typedef struct {
        logic        u1, u2, ud;
        logic [5:0]  rs1, rs2, rd;
        logic [4:0]  al;
        logic [1:0]  cp;
        logic [95:0] pl;
        bit          r1, r2;
    } m_ent_t;

    m_ent_t mq[$];
    m_ent_t nq[$];
    m_ent_t ex;
    int     e;
    bit     stall_m;

    function automatic bit woke(input logic [5:0] tag);
        return (wb_valid[0] && wb_tag[0] == tag) || (wb_valid[1] && wb_tag[1] == tag);
    endfunction

    function automatic bit sq(input logic [1:0] cp);
        return squash_valid && squash_mask[cp];
    endfunction

    function automatic bit rdy_at_enq(input int s, input logic uses, input logic [5:0] tag);
        if (!uses || tag == 0) return 1;
        if (s == 1 && in_valid[0] && in_uses_rd[0] && in_rd[0] == tag) return 0;
        return !bbt[tag] || woke(tag);
    endfunction

    function automatic logic [123:0] pack_m(input m_ent_t m);
        return {m.u1, m.u2, m.ud, m.rs1, m.rs2, m.rd, m.al, m.cp, m.pl};
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model over the edge.
    always @(negedge clk) begin
        if (live) begin
            e = -1;
            if (!flush) begin
                for (int k = 0; k < mq.size(); k++) begin
                    if (e < 0 && mq[k].r1 && mq[k].r2 && !sq(mq[k].cp)) e = k;
                end
            end
            stall_m = (DEPTH - mq.size()) < 2;
            chk("model_stall", o_stall, stall_m);
            chk("model_iss_valid", iss_valid, e >= 0);
            if (e >= 0) chk("model_iss_fields",
                            {iss_uses_rs1, iss_uses_rs2, iss_uses_rd, iss_rs1, iss_rs2, iss_rd,
                             iss_al_idx, iss_cp, iss_payload}, pack_m(mq[e]));
            else chk("model_idle_fields",
                     {iss_uses_rs1, iss_uses_rs2, iss_uses_rd, iss_rs1, iss_rs2, iss_rd,
                      iss_al_idx, iss_cp, iss_payload}, '0);
            if (reset || flush) begin
                mq.delete();
            end else begin
                nq.delete();
                for (int k = 0; k < mq.size(); k++) begin
                    ex = mq[k];
                    if (!sq(ex.cp) && !(k == e && iss_ready)) begin
                        if (woke(ex.rs1)) ex.r1 = 1;
                        if (woke(ex.rs2)) ex.r2 = 1;
                        nq.push_back(ex);
                    end
                end
                if (!stall_m) begin
                    for (int s = 0; s < 2; s++) begin
                        if (in_valid[s] && !sq(in_cp[s])) begin
                            ex.u1 = in_uses_rs1[s]; ex.u2 = in_uses_rs2[s]; ex.ud = in_uses_rd[s];
                            ex.rs1 = in_rs1[s]; ex.rs2 = in_rs2[s]; ex.rd = in_rd[s];
                            ex.al = in_al_idx[s]; ex.cp = in_cp[s]; ex.pl = in_payload[s];
                            ex.r1 = rdy_at_enq(s, in_uses_rs1[s], in_rs1[s]);
                            ex.r2 = rdy_at_enq(s, in_uses_rs2[s], in_rs2[s]);
                            nq.push_back(ex);
                        end
                    end
                end
                mq = nq;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 0; in_uses_rs1[s] = 0; in_uses_rs2[s] = 0; in_uses_rd[s] = 0;
            in_rs1[s] = '0; in_rs2[s] = '0; in_rd[s] = '0; in_al_idx[s] = '0;
            in_cp[s] = '0; in_payload[s] = '0;
        end
        for (int w = 0; w < 2; w++) begin
            wb_valid[w] = 0; wb_tag[w] = '0;
        end
        squash_valid = 0; squash_mask = '0; flush = 0;
    endtask

    task automatic set_slot(input int s, input bit u1, input int r1, input bit u2, input int r2,
                            input bit ud, input int rd, input int cp);
        in_valid[s] = 1; in_uses_rs1[s] = u1; in_uses_rs2[s] = u2; in_uses_rd[s] = ud;
        in_rs1[s] = 6'(r1); in_rs2[s] = 6'(r2); in_rd[s] = 6'(rd);
        in_al_idx[s] = 5'(rd); in_cp[s] = 2'(cp);
        in_payload[s] = {32'(rd), 64'h0123_4567_89ab_cdef};
    endtask

    task automatic wake(input int tag);
        wb_valid[0] = 1; wb_tag[0] = 6'(tag);
    endtask

    initial begin
        reset = 1; bbt = '0; iss_ready = 0;
        clear_in();
        tick();
        live = 1;
        tick();
        reset = 0;
        #1;
        chk("reset_iss_valid", iss_valid, 0);
        chk("reset_stall", o_stall, 0);
        chk("reset_fields", {iss_rs1, iss_rs2, iss_rd, iss_al_idx, iss_cp, iss_payload}, 0);

        // Single ready add: issues the cycle after enqueue.
        set_slot(0, 1, 5, 1, 0, 1, 7, 0);
        tick(); clear_in(); iss_ready = 1; #1;
        chk("t1_valid", iss_valid, 1);
        chk("t1_rs1", iss_rs1, 5);
        tick(); #1;
        chk("t1_empty", iss_valid, 0);
        chk("t1_stall", o_stall, 0);

        // Intra-bundle dependence on p9; B waits for the wakeup.
        bbt[9] = 1;
        set_slot(0, 1, 0, 0, 0, 1, 9, 0);
        set_slot(1, 1, 9, 0, 0, 1, 10, 0);
        tick(); clear_in(); #1;
        chk("t2_a_valid", iss_valid, 1);
        chk("t2_a_rd", iss_rd, 9);
        tick(); #1;
        chk("t2_b_waits", iss_valid, 0);
        wake(9);
        tick(); clear_in(); #1;
        chk("t2_b_valid", iss_valid, 1);
        chk("t2_b_rs1", iss_rs1, 9);
        tick(); #1;
        chk("t2_empty", iss_valid, 0);
        bbt = '0;

        // Fill 7 entries behind busy p12, then drain in insertion order.
        iss_ready = 0; bbt[12] = 1;
        for (int k = 0; k < 3; k++) begin
            set_slot(0, 1, 12, 0, 0, 1, 20 + 2 * k, 0);
            set_slot(1, 1, 12, 0, 0, 1, 21 + 2 * k, 0);
            tick(); clear_in();
        end
        set_slot(0, 1, 12, 0, 0, 1, 26, 0);
        tick(); clear_in(); #1;
        chk("t3_stall", o_stall, 1);
        set_slot(0, 0, 0, 0, 0, 1, 50, 0);
        set_slot(1, 0, 0, 0, 0, 1, 51, 0);
        tick(); tick(); #1;
        chk("t3_ignored", iss_valid, 0);
        chk("t3_still_stall", o_stall, 1);
        clear_in(); wake(12); iss_ready = 1;
        tick(); clear_in();
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("t3_order_valid", iss_valid, 1);
            chk("t3_order_rd", iss_rd, 20 + k);
            tick();
        end
        #1;
        chk("t3_drained", iss_valid, 0);
        chk("t3_unstall", o_stall, 0);
        bbt = '0;

        // Selection held while the consumer back-pressures.
        iss_ready = 0;
        set_slot(0, 0, 0, 0, 0, 1, 30, 0);
        set_slot(1, 0, 0, 0, 0, 1, 31, 0);
        tick(); clear_in();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_hold_rd", iss_rd, 30);
            tick();
        end
        iss_ready = 1; #1;
        chk("t4_first", iss_rd, 30);
        tick(); #1;
        chk("t4_second", iss_rd, 31);
        tick(); #1;
        chk("t4_empty", iss_valid, 0);

        // Squash cp=1: two queued entries and a same-cycle enqueue vanish.
        bbt[13] = 1;
        set_slot(0, 1, 13, 0, 0, 1, 40, 1);
        set_slot(1, 1, 13, 0, 0, 1, 41, 2);
        tick(); clear_in();
        set_slot(0, 1, 13, 0, 0, 1, 42, 1);
        tick(); clear_in();
        squash_valid = 1; squash_mask = 4'b0010;
        set_slot(0, 0, 0, 0, 0, 1, 43, 1);
        tick(); clear_in(); #1;
        chk("t5_dropped", iss_valid, 0);
        wake(13);
        tick(); clear_in(); #1;
        chk("t5_survivor_valid", iss_valid, 1);
        chk("t5_survivor_rd", iss_rd, 41);
        chk("t5_survivor_cp", iss_cp, 2);
        tick(); #1;
        chk("t5_empty", iss_valid, 0);
        bbt = '0;

        // Flush together with enqueue and wakeup.
        bbt[14] = 1;
        set_slot(0, 1, 14, 0, 0, 1, 60, 0);
        set_slot(1, 1, 14, 0, 0, 1, 61, 0);
        tick(); clear_in();
        flush = 1; wake(14);
        set_slot(0, 0, 0, 0, 0, 1, 62, 0);
        set_slot(1, 0, 0, 0, 0, 1, 63, 0);
        tick(); clear_in(); #1;
        chk("t6_valid", iss_valid, 0);
        chk("t6_stall", o_stall, 0);
        tick(); #1;
        chk("t6_still_empty", iss_valid, 0);
        bbt = '0;

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            for (int s = 0; s < 2; s++) begin
                in_valid[s]    = $urandom_range(0, 99) < 45;
                in_uses_rs1[s] = $urandom_range(0, 3) != 0;
                in_uses_rs2[s] = $urandom_range(0, 1) != 0;
                in_uses_rd[s]  = $urandom_range(0, 3) != 0;
                in_rs1[s]      = 6'($urandom_range(0, 15));
                in_rs2[s]      = 6'($urandom_range(0, 15));
                in_rd[s]       = 6'($urandom_range(0, 15));
                in_al_idx[s]   = 5'($urandom);
                in_cp[s]       = 2'($urandom);
                in_payload[s]  = {$urandom, $urandom, $urandom};
            end
            for (int w = 0; w < 2; w++) begin
                wb_valid[w] = $urandom_range(0, 99) < 40;
                wb_tag[w]   = 6'($urandom_range(0, 15));
            end
            bbt          = {$urandom, $urandom};
            squash_valid = $urandom_range(0, 15) == 0;
            squash_mask  = 4'($urandom);
            flush        = $urandom_range(0, 99) == 0;
            iss_ready    = $urandom_range(0, 3) != 0;
            tick();
        end
        clear_in();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
